writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//  Parametrised multi-lane writeback stage for the dual-issue pipeline.
//  - Accepts up to LANES retiring results per cycle.
//  - Performs load-data extraction (byte/half select, sign/zero extend).
//  - Buffers results in an in-order circular queue.
//  - Drains up to WPORTS entries per cycle to the register file.
//  Sits between the memory-stage register and the regfile. Provides a
//  newest-wins forwarding lookup so decode/execute see pending results.
// PARAMETERS
//  LANES   2   results presented per cycle; lane 0 is oldest
//  DEPTH   4   queue entries; power of 2, DEPTH >= LANES
//  WPORTS  1   regfile write ports drained per cycle; 1 <= WPORTS <= LANES
// PORTS
//  clk         in   1          clock, rising edge
//  resetn      in   1          asynchronous reset, active low
//  in_valid    in   LANES      lane k carries a regwrite result
//  in_ready    out  1          1: all presented lanes accepted this cycle
//  in_id       in   LANES*5    destination register per lane
//  in_aluout   in   LANES*32   ALU result; for loads, byte address in [1:0]
//  in_memread  in   LANES      lane is a load; result comes from in_rd
//  in_memtype  in   LANES*3    0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW
//  in_rd       in   LANES*32   raw aligned memory word
//  rf_valid    out  WPORTS     regfile write enable per port
//  rf_id       out  WPORTS*5   regfile write index
//  rf_data     out  WPORTS*32  regfile write data
//  fwd_id      in   5          forwarding lookup register
//  fwd_hit     out  1          a pending or incoming result targets fwd_id
//  fwd_data    out  32         newest such result
//  count       out  clog2(DEPTH+1)  occupied entries (registered)
// BEHAVIOUR
//  Reset (async, resetn=0):
//  - Head, tail and count = 0; rf_valid = 0; in_ready = 1.
//  - fwd_hit = 0; queue contents discarded, including mid-drain entries.
//  Result formation (combinational, per lane):
//  - memread=0: result = aluout.
//  - memread=1: byte/half selected by aluout[1:0] (little endian).
//    LB/LH sign-extend; LBU/LHU zero-extend; LW passes in_rd.
//  - LH/LHU use aluout[1]. Undefined memtype 5-7 yields in_rd.
//  Acceptance:
//  - in_ready = (DEPTH - count) >= LANES. Combinational from the registered
//    count, independent of in_valid.
//  - Accepted when in_ready=1. Valid lanes with id != 0 are compacted in lane
//    order into tail..tail+n-1. Lanes with id == 0 are accepted and dropped.
//  - When in_ready=0, inputs are ignored. Upstream holds them stable.
//  Drain:
//  - Each cycle, rf port j presents entry head+j if j < count (rf_valid[j]=1).
//  - These outputs are combinational from queue state; head advances by
//    min(count, WPORTS).
//  - A result accepted in cycle t is written no earlier than cycle t+1.
//    It is written at t+1 when the queue was empty.
//  - Higher port index is younger. When two ports write the same id in one
//    cycle, the regfile gives the highest port priority.
//  Simultaneous enqueue and drain:
//  - count_next = count + accepted - drained. Legal at any occupancy,
//    including full, where drain frees slots only for the next cycle.
//  - Pointers wrap modulo DEPTH.
//  Forwarding:
//  - Search queue entries (not yet drained this cycle or later) plus lanes
//    accepted this cycle.
//  - Priority: highest accepted lane > youngest queue entry > older.
//  - fwd_id == 0 gives hit 0 and data 0. Entries being drained this cycle
//    still match.
//  count never exceeds DEPTH. Overflow is impossible by construction;
//  assertion count <= DEPTH.
// TESTING
//  1. Reset, then lane0 id=3 aluout=0x1234, empty queue
//     -> next cycle rf_valid=1, id 3, data 0x1234; count back to 0.
//  2. LB, in_rd=0x80FF7F01, aluout[1:0]=3 -> 0xFFFFFF80.
//     LHU with addr 2 -> 0x000080FF. LH with addr 0 -> 0x00007F01.
//  3. LANES=2, WPORTS=1, both lanes valid 4 cycles in a row
//     -> in_ready drops when count > 2; lanes drain in order lane0 then lane1;
//     no loss or duplication.
//  4. Lanes write id 5 = 0xA, then id 5 = 0xB, queued
//     -> fwd_id=5 returns 0xB. An incoming lane id 5 = 0xC overrides -> 0xC.
//     fwd_id=0 -> hit 0.
//  5. Full queue (count=4), drain plus both lanes valid
//     -> in_ready=0 this cycle; accepted next cycle when count=3... held until
//     free >= 2.
//  6. Assert resetn low with 3 entries pending
//     -> rf_valid=0 immediately; count=0; pending writes never reach regfile.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Bundles the writeback stage's upstream result lanes, regfile write
// ports, forwarding lookup and occupancy into one interface.
//
// Handshake: the lanes in in_valid are transferred on a rising clk edge
// exactly when in_ready is 1 at that edge. in_ready depends only on the
// registered occupancy, never on in_valid. While in_ready is 0 the
// upstream side holds every in_* signal stable. rf_valid[j] carries no
// back-pressure: the regfile always takes a presented write.
interface writeback_queue_if #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int WPORTS = 1
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LANES-1:0]    in_valid;
  logic                in_ready;
  logic [LANES*5-1:0]  in_id;
  logic [LANES*32-1:0] in_aluout;
  logic [LANES-1:0]    in_memread;
  logic [LANES*3-1:0]  in_memtype;
  logic [LANES*32-1:0] in_rd;

  logic [WPORTS-1:0]    rf_valid;
  logic [WPORTS*5-1:0]  rf_id;
  logic [WPORTS*32-1:0] rf_data;

  logic [4:0]  fwd_id;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  logic [CW-1:0] count;

  // Upstream pipeline / regfile / lookup side.
  modport master (
    output in_valid, in_id, in_aluout, in_memread, in_memtype, in_rd, fwd_id,
    input  in_ready, rf_valid, rf_id, rf_data, fwd_hit, fwd_data, count
  );

  // Writeback queue side.
  modport slave (
    input  in_valid, in_id, in_aluout, in_memread, in_memtype, in_rd, fwd_id,
    output in_ready, rf_valid, rf_id, rf_data, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/writeback_queue.sv
// Multi-lane writeback stage: forms load results, compacts retiring lanes
// into an in-order circular queue, drains up to WPORTS entries per cycle to
// the register file and offers a newest-wins forwarding lookup.
module writeback_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int WPORTS = 1
) (
  input  logic               clk,
  input  logic               resetn,
  writeback_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Queue storage; contents are only meaningful inside head..head+count-1.
  logic [4:0]  id_q   [DEPTH];
  logic [31:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] n_acc;
  logic [CW-1:0] n_drn;
  logic          ready;

  logic [31:0]      lane_res [LANES];
  logic [LANES-1:0] lane_acc;

  logic [DEPTH-1:0] wr_en;
  logic [4:0]       wr_id   [DEPTH];
  logic [31:0]      wr_data [DEPTH];

  logic [PW-1:0] wslot, rslot, fslot;
  logic          fwd_hit_c;
  logic [31:0]   fwd_data_c;

  // Load extraction: little-endian byte/half select plus sign/zero extend.
  function automatic logic [31:0] form_result(
    input logic [31:0] alu,
    input logic        mr,
    input logic [2:0]  mt,
    input logic [31:0] rd
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{alu[1:0], 3'b000} +: 8];
    h = rd[{alu[1], 4'b0000} +: 16];
    r = rd;
    if (!mr) begin
      r = alu;
    end else begin
      case (mt)
        3'd0:    r = {{24{b[7]}}, b};
        3'd1:    r = {24'h0, b};
        3'd2:    r = {{16{h[15]}}, h};
        3'd3:    r = {16'h0, h};
        default: r = rd;
      endcase
    end
    return r;
  endfunction

  // Free space check uses only registered occupancy, so in_ready never
  // depends on what upstream is presenting.
  assign ready       = (CW'(DEPTH) - count_q) >= CW'(LANES);
  assign bus.in_ready = ready;
  assign bus.count    = count_q;

  // Per-lane result and whether the lane actually lands in the queue.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_res[k] = form_result(bus.in_aluout[k*32 +: 32], bus.in_memread[k],
                                bus.in_memtype[k*3 +: 3], bus.in_rd[k*32 +: 32]);
      lane_acc[k] = ready && bus.in_valid[k] && (bus.in_id[k*5 +: 5] != 5'd0);
    end
  end

  // Compact accepted lanes, in lane order, into consecutive slots from tail.
  always_comb begin
    wr_en = '0;
    n_acc = '0;
    wslot = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      wr_id[i]   = '0;
      wr_data[i] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (lane_acc[k]) begin
        wslot          = tail_q + PW'(n_acc);
        wr_en[wslot]   = 1'b1;
        wr_id[wslot]   = bus.in_id[k*5 +: 5];
        wr_data[wslot] = lane_res[k];
        n_acc          = n_acc + CW'(1);
      end
    end
  end

  // Pointer and occupancy bookkeeping; drain never exceeds what is stored.
  always_comb begin
    n_drn   = (count_q < CW'(WPORTS)) ? count_q : CW'(WPORTS);
    head_d  = head_q + PW'(n_drn);
    tail_d  = tail_q + PW'(n_acc);
    count_d = count_q + n_acc - n_drn;
  end

  // Regfile ports show the oldest entries; higher port index is younger.
  always_comb begin
    bus.rf_valid = '0;
    bus.rf_id    = '0;
    bus.rf_data  = '0;
    rslot        = head_q;
    for (int j = 0; j < WPORTS; j++) begin
      rslot                   = head_q + PW'(j);
      bus.rf_valid[j]         = CW'(j) < count_q;
      bus.rf_id[j*5 +: 5]     = id_q[rslot];
      bus.rf_data[j*32 +: 32] = data_q[rslot];
    end
  end

  // Forwarding: scan oldest to youngest so the last match is the newest;
  // lanes being accepted this cycle are younger than anything queued.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fslot      = head_q;
    if (bus.fwd_id != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        fslot = head_q + PW'(i);
        if ((CW'(i) < count_q) && (id_q[fslot] == bus.fwd_id)) begin
          fwd_hit_c  = 1'b1;
          fwd_data_c = data_q[fslot];
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if (lane_acc[k] && (bus.in_id[k*5 +: 5] == bus.fwd_id)) begin
          fwd_hit_c  = 1'b1;
          fwd_data_c = lane_res[k];
        end
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit_c;
  assign bus.fwd_data = fwd_data_c;

  // Pointers and count; reset discards every pending entry at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        id_q[i]   <= wr_id[i];
        data_q[i] <= wr_data[i];
      end
    end
  end

  count_le_depth: assert property (@(posedge clk) disable iff (!resetn)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (LANES=2, DEPTH=4, WPORTS=1).
module tb_writeback_queue;
  logic clk;
  logic resetn;

  int n_cmp;
  int n_err;

  logic [36:0] exp_q[$];

  writeback_queue_if #(.LANES(2), .DEPTH(4), .WPORTS(1)) bus ();

  writeback_queue #(.LANES(2), .DEPTH(4), .WPORTS(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.in_valid   = '0;
    bus.in_id      = '0;
    bus.in_aluout  = '0;
    bus.in_memread = '0;
    bus.in_memtype = '0;
    bus.in_rd      = '0;
    bus.fwd_id     = '0;
  endtask

  task automatic set_lane(input int k, input logic [4:0] id, input logic [31:0] alu,
                          input logic mr, input logic [2:0] mt, input logic [31:0] rd);
    bus.in_valid[k]          = 1'b1;
    bus.in_id[k*5 +: 5]      = id;
    bus.in_aluout[k*32 +: 32] = alu;
    bus.in_memread[k]        = mr;
    bus.in_memtype[k*3 +: 3] = mt;
    bus.in_rd[k*32 +: 32]    = rd;
  endtask

  // Called just after a negedge with inputs cleared; bounded wait for empty.
  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    #1;
    while (bus.count !== 3'd0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(bus.count), 32'd0);
  endtask

  localparam logic [31:0] MEMW = 32'h80FF7F01;

  int          pres  [10] = '{0, 1, 2, 2, 3, 3, -1, -1, -1, -1};
  logic        e_rdy [10] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
  logic [2:0]  e_cnt [10] = '{0, 2, 3, 2, 3, 2, 3, 2, 1, 0};
  logic        e_rfv [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    logic [36:0] e;
    logic [4:0]  id0, id1;
    n_cmp = 0;
    n_err = 0;

    // Reset state.
    clear_in();
    resetn = 1'b0;
    bus.fwd_id = 5'd3;
    @(negedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rf_valid", 32'(bus.rf_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Single result through an empty queue.
    @(negedge clk);
    set_lane(0, 5'd3, 32'h1234, 1'b0, 3'd0, 32'h0);
    bus.fwd_id = 5'd3;
    #1;
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t1_fwd_hit_incoming", 32'(bus.fwd_hit), 32'd1);
    chk("t1_fwd_data_incoming", bus.fwd_data, 32'h1234);
    chk("t1_rf_valid_same_cycle", 32'(bus.rf_valid), 32'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_rf_valid", 32'(bus.rf_valid), 32'd1);
    chk("t1_rf_id", 32'(bus.rf_id), 32'd3);
    chk("t1_rf_data", bus.rf_data, 32'h1234);
    @(negedge clk);
    #1;
    chk("t1_count_after", 32'(bus.count), 32'd0);
    chk("t1_rf_valid_after", 32'(bus.rf_valid), 32'd0);

    // Load extraction: LB addr 3, LHU addr 2.
    @(negedge clk);
    set_lane(0, 5'd7, 32'h2003, 1'b1, 3'd0, MEMW);
    set_lane(1, 5'd8, 32'h2002, 1'b1, 3'd3, MEMW);
    bus.fwd_id = 5'd7;
    #1;
    chk("t2_lb_addr3", bus.fwd_data, 32'hFFFFFF80);
    bus.fwd_id = 5'd8;
    #1;
    chk("t2_lhu_addr2", bus.fwd_data, 32'h000080FF);
    @(negedge clk);
    clear_in();
    #1;
    chk("t2_count2", 32'(bus.count), 32'd2);
    chk("t2_rf_id_lane0", 32'(bus.rf_id), 32'd7);
    chk("t2_rf_data_lane0", bus.rf_data, 32'hFFFFFF80);
    @(negedge clk);
    #1;
    chk("t2_rf_id_lane1", 32'(bus.rf_id), 32'd8);
    chk("t2_rf_data_lane1", bus.rf_data, 32'h000080FF);

    // LH addr 0 on lane 0; lane 1 valid with id 0 must be dropped.
    @(negedge clk);
    set_lane(0, 5'd9, 32'h2000, 1'b1, 3'd2, MEMW);
    set_lane(1, 5'd0, 32'hDEAD, 1'b0, 3'd0, 32'h0);
    bus.fwd_id = 5'd9;
    #1;
    chk("t2_count0", 32'(bus.count), 32'd0);
    chk("t2_lh_addr0", bus.fwd_data, 32'h00007F01);
    bus.fwd_id = 5'd0;
    #1;
    chk("t2_fwd_id0_hit", 32'(bus.fwd_hit), 32'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("t2_id0_dropped_count", 32'(bus.count), 32'd1);
    chk("t2_rf_id_lh", 32'(bus.rf_id), 32'd9);
    chk("t2_rf_data_lh", bus.rf_data, 32'h00007F01);

    // LBU addr 1 and an undefined memtype (passes the raw word).
    @(negedge clk);
    set_lane(0, 5'd10, 32'h2001, 1'b1, 3'd1, MEMW);
    set_lane(1, 5'd11, 32'h2002, 1'b1, 3'd6, MEMW);
    bus.fwd_id = 5'd10;
    #1;
    chk("t2_lbu_addr1", bus.fwd_data, 32'h0000007F);
    bus.fwd_id = 5'd11;
    #1;
    chk("t2_memtype6", bus.fwd_data, MEMW);
    @(negedge clk);
    clear_in();
    wait_empty("t2_drain_empty");

    // Back-to-back pairs: acceptance throttles, drain stays in order.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clear_in();
      if (pres[c] >= 0) begin
        id0 = 5'(11 + 2 * pres[c]);
        id1 = 5'(12 + 2 * pres[c]);
        set_lane(0, id0, 32'h100 + 32'(id0), 1'b0, 3'd0, 32'h0);
        set_lane(1, id1, 32'h100 + 32'(id1), 1'b0, 3'd0, 32'h0);
      end
      #1;
      chk($sformatf("t3_ready_c%0d", c), 32'(bus.in_ready), 32'(e_rdy[c]));
      chk($sformatf("t3_count_c%0d", c), 32'(bus.count), 32'(e_cnt[c]));
      chk($sformatf("t3_rf_valid_c%0d", c), 32'(bus.rf_valid), 32'(e_rfv[c]));
      if (e_rfv[c]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk($sformatf("t3_rf_id_c%0d", c), 32'(bus.rf_id), 32'(e[36:32]));
        chk($sformatf("t3_rf_data_c%0d", c), bus.rf_data, e[31:0]);
      end
      if (pres[c] >= 0 && e_rdy[c]) begin
        exp_q.push_back({id0, 32'h100 + 32'(id0)});
        exp_q.push_back({id1, 32'h100 + 32'(id1)});
      end
    end
    chk("t3_no_loss", 32'(exp_q.size()), 32'd0);

    // Forwarding priority.
    @(negedge clk);
    clear_in();
    set_lane(0, 5'd5, 32'hA, 1'b0, 3'd0, 32'h0);
    set_lane(1, 5'd6, 32'h66, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    clear_in();
    set_lane(0, 5'd5, 32'hB, 1'b0, 3'd0, 32'h0);
    set_lane(1, 5'd7, 32'h77, 1'b0, 3'd0, 32'h0);
    bus.fwd_id = 5'd5;
    #1;
    chk("t4_incoming_over_queue", bus.fwd_data, 32'hB);
    @(negedge clk);
    clear_in();
    bus.fwd_id = 5'd5;
    #1;
    chk("t4_queued_hit", 32'(bus.fwd_hit), 32'd1);
    chk("t4_queued_data", bus.fwd_data, 32'hB);
    bus.fwd_id = 5'd6;
    #1;
    chk("t4_draining_rf_id", 32'(bus.rf_id), 32'd6);
    chk("t4_draining_still_hits", bus.fwd_data, 32'h66);
    @(negedge clk);
    clear_in();
    set_lane(0, 5'd5, 32'hD, 1'b0, 3'd0, 32'h0);
    set_lane(1, 5'd5, 32'hC, 1'b0, 3'd0, 32'h0);
    bus.fwd_id = 5'd5;
    #1;
    chk("t4_ready", 32'(bus.in_ready), 32'd1);
    chk("t4_highest_lane", bus.fwd_data, 32'hC);
    bus.fwd_id = 5'd0;
    #1;
    chk("t4_fwd0_hit", 32'(bus.fwd_hit), 32'd0);
    chk("t4_fwd0_data", bus.fwd_data, 32'd0);
    bus.fwd_id = 5'd20;
    #1;
    chk("t4_miss_hit", 32'(bus.fwd_hit), 32'd0);
    @(negedge clk);
    clear_in();
    bus.fwd_id = 5'd5;
    #1;
    chk("t4_count3", 32'(bus.count), 32'd3);
    chk("t4_youngest_entry", bus.fwd_data, 32'hC);
    chk("t4_rf_id7", 32'(bus.rf_id), 32'd7);
    @(negedge clk);
    clear_in();
    wait_empty("t4_drain_empty");

    // Reset with entries pending.
    @(negedge clk);
    set_lane(0, 5'd21, 32'h21, 1'b0, 3'd0, 32'h0);
    set_lane(1, 5'd22, 32'h22, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    clear_in();
    set_lane(0, 5'd23, 32'h23, 1'b0, 3'd0, 32'h0);
    set_lane(1, 5'd24, 32'h24, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    clear_in();
    #1;
    chk("t6_count3", 32'(bus.count), 32'd3);
    resetn = 1'b0;
    bus.fwd_id = 5'd23;
    #1;
    chk("t6_rf_valid_now", 32'(bus.rf_valid), 32'd0);
    chk("t6_count_now", 32'(bus.count), 32'd0);
    chk("t6_ready_now", 32'(bus.in_ready), 32'd1);
    chk("t6_fwd_hit_now", 32'(bus.fwd_hit), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t6_no_write_c%0d", c), 32'(bus.rf_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
